// File: rtl/washer_pkg.sv
// Shared types for the phase timer: FSM states, one-hot phase codes, program level.
package washer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [3:0] phase_t;
    typedef logic [1:0] level_t;

    localparam int     N_PHASES = 4;
    localparam phase_t PH_NONE  = 4'b0000;
    localparam phase_t PH_SOAK  = 4'b0001;
    localparam phase_t PH_WASH  = 4'b0010;
    localparam phase_t PH_RINSE = 4'b0100;
    localparam phase_t PH_SPIN  = 4'b1000;

    function automatic logic is_multi_hot(input phase_t v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    function automatic logic is_one_hot(input phase_t v);
        return (v != 4'd0) && !is_multi_hot(v);
    endfunction

endpackage

// File: rtl/phase_timer_tick_down_counter.sv
// Loadable down-counter with clear, enable-gated decrement and zero/one flags.
module tick_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count   = count_reg;
    assign is_zero = (count_reg == '0);
    assign is_one  = (count_reg == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/phase_timer.sv
// Wash-cycle phase timer: times one enabled phase for BASE*level ticks and pulses its done flag.
// Optional door pause feature enabled by defining PHASE_TIMER_PAUSE_EN.
module phase_timer
    import washer_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int SOAK_BASE  = 10,
    parameter int WASH_BASE  = 15,
    parameter int RINSE_BASE = 10,
    parameter int SPIN_BASE  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ready1,
    input  logic             ready2,
    input  logic             ready3,
    input  logic             soak,
    input  logic             wash,
    input  logic             rinse,
    input  logic             spin,
`ifdef PHASE_TIMER_PAUSE_EN
    input  logic             door_open,
`endif
    output logic             soaked,
    output logic             washed,
    output logic             rinsed,
    output logic             spun,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
`ifdef PHASE_TIMER_PAUSE_EN
    output logic             paused,
`endif
    output logic             phase_err
);

    localparam logic [CNT_W+1:0] SAT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t           state_reg, state_next;
    phase_t           phase_reg, phase_next;
    phase_t           done_reg,  done_next;
    level_t           level_reg;
    logic             err_reg;
    phase_t           phase_vec;
    logic             multi_hot;
    logic             count_hold;
    logic             cnt_load, cnt_clear, cnt_dec;
    logic             cnt_zero, cnt_one;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] dur [N_PHASES];

    assign phase_vec = {spin, rinse, wash, soak};
    assign multi_hot = is_multi_hot(phase_vec);

`ifdef PHASE_TIMER_PAUSE_EN
    logic paused_reg;
    assign count_hold = door_open;
`else
    assign count_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= 2'd1;
        end else if (ready3) begin
            level_reg <= 2'd3;
        end else if (ready2) begin
            level_reg <= 2'd2;
        end else if (ready1) begin
            level_reg <= 2'd1;
        end
    end

    // Per-phase duration, widened by two bits so BASE*3 can be detected and saturated.
    generate
        for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_dur
            localparam int BASE = (gi == 0) ? SOAK_BASE :
                                  (gi == 1) ? WASH_BASE :
                                  (gi == 2) ? RINSE_BASE : SPIN_BASE;
            logic [CNT_W+1:0] prod;
            assign prod    = (CNT_W+2)'(BASE) * (CNT_W+2)'(level_reg);
            assign dur[gi] = (prod > SAT_MAX) ? {CNT_W{1'b1}} : prod[CNT_W-1:0];
        end
    endgenerate

    always_comb begin
        load_value = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (phase_vec[i]) begin
                load_value = dur[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        done_next  = PH_NONE;
        cnt_load   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_dec    = 1'b0;
        if (multi_hot) begin
            state_next = ST_IDLE;
            phase_next = PH_NONE;
            cnt_clear  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (phase_vec != PH_NONE) begin
                        state_next = ST_RUN;
                        phase_next = phase_vec;
                        cnt_load   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (phase_vec == PH_NONE) begin
                        state_next = ST_IDLE;
                        phase_next = PH_NONE;
                        cnt_clear  = 1'b1;
                    end else if (phase_vec != phase_reg) begin
                        phase_next = phase_vec;
                        cnt_load   = 1'b1;
                    end else if (tick && !count_hold) begin
                        // A zero-length phase (BASE of 0) completes on its first tick.
                        if (cnt_one || cnt_zero) begin
                            state_next = ST_DONE;
                            done_next  = phase_reg;
                            cnt_clear  = 1'b1;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (phase_vec != phase_reg) begin
                        state_next = ST_IDLE;
                        phase_next = PH_NONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    phase_next = PH_NONE;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            phase_reg <= PH_NONE;
            done_reg  <= PH_NONE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            done_reg  <= done_next;
            err_reg   <= multi_hot;
        end
    end

`ifdef PHASE_TIMER_PAUSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            paused_reg <= 1'b0;
        end else begin
            paused_reg <= (state_next == ST_RUN) && door_open;
        end
    end
    assign paused = paused_reg;
`endif

    tick_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (load_value),
        .dec        (cnt_dec),
        .count      (remaining),
        .is_zero    (cnt_zero),
        .is_one     (cnt_one)
    );

    assign soaked    = done_reg[0];
    assign washed    = done_reg[1];
    assign rinsed    = done_reg[2];
    assign spun      = done_reg[3];
    assign busy      = (state_reg == ST_RUN);
    assign phase_err = err_reg;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: done pulses go through a scoreboard queue, levels are checked inline.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_s = 1'b1;
    logic       tick = 1'b0;
    logic       ready1 = 1'b0, ready2 = 1'b0, ready3 = 1'b0;
    logic       soak = 1'b0, wash = 1'b0, rinse = 1'b0, spin = 1'b0;
`ifdef PHASE_TIMER_PAUSE_EN
    logic       door_open = 1'b0;
    logic       paused_m, paused_s;
`endif

    logic       soaked_m, washed_m, rinsed_m, spun_m, busy_m, err_m;
    logic [7:0] rem_m;
    logic       soaked_s, washed_s, rinsed_s, spun_s, busy_s, err_s;
    logic [3:0] rem_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         id;
        logic [3:0] vec;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phase_timer dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ready1(ready1), .ready2(ready2), .ready3(ready3),
        .soak(soak), .wash(wash), .rinse(rinse), .spin(spin),
`ifdef PHASE_TIMER_PAUSE_EN
        .door_open(door_open), .paused(paused_m),
`endif
        .soaked(soaked_m), .washed(washed_m), .rinsed(rinsed_m), .spun(spun_m),
        .remaining(rem_m), .busy(busy_m), .phase_err(err_m)
    );

    phase_timer #(.CNT_W(4), .SOAK_BASE(10)) dut_small (
        .clk(clk), .rst(rst_s), .tick(tick),
        .ready1(ready1), .ready2(ready2), .ready3(ready3),
        .soak(soak), .wash(wash), .rinse(rinse), .spin(spin),
`ifdef PHASE_TIMER_PAUSE_EN
        .door_open(door_open), .paused(paused_s),
`endif
        .soaked(soaked_s), .washed(washed_s), .rinsed(rinsed_s), .spun(spun_s),
        .remaining(rem_s), .busy(busy_s), .phase_err(err_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ph(input logic [3:0] v);
        {spin, rinse, wash, soak} = v;
    endtask

    task automatic expect_pulse(input int id, input logic [3:0] v, input int at);
        exp_t e;
        e.id = id; e.vec = v; e.at = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every done pulse from either instance must match the head of the queue.
    task automatic check_pulse(input int id, input logic [3:0] v);
        exp_t e;
        if (v == 4'd0) return;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_pulse: dut %0d done=%b at cycle %0d, none expected", id, v, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("pulse_dut%0d", id), id, e.id);
        chk("pulse_vec", int'(v), int'(e.vec));
        chk("pulse_cycle", cyc, e.at);
    endtask

    always @(negedge clk) begin
        check_pulse(0, {spun_m, rinsed_m, washed_m, soaked_m});
        check_pulse(1, {spun_s, rinsed_s, washed_s, soaked_s});
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int l;
        step(2);
        chk("rst_remaining", int'(rem_m), 0);
        chk("rst_busy", int'(busy_m), 0);
        chk("rst_err", int'(err_m), 0);
        chk("rst_done", int'({spun_m, rinsed_m, washed_m, soaked_m}), 0);
        rst = 1'b0;
        step(1);

        // Default level 1: soak loads 10, tick held low so nothing counts.
        set_ph(4'b0001);
        step(1);
        chk("lvl1_load", int'(rem_m), 10);
        chk("lvl1_busy", int'(busy_m), 1);
        step(3);
        chk("no_tick_hold", int'(rem_m), 10);
        set_ph(4'b0000);
        step(1);
        chk("cancel_rem", int'(rem_m), 0);

        // Level 2 soak, full run.
        ready2 = 1'b1; step(1); ready2 = 1'b0;
        set_ph(4'b0001); tick = 1'b1;
        step(1);
        l = cyc;
        chk("soak_load", int'(rem_m), 20);
        expect_pulse(0, 4'b0001, l + 20);
        step(19);
        chk("soak_rem1", int'(rem_m), 1);
        chk("soak_busy", int'(busy_m), 1);
        step(1);
        chk("soak_done_rem", int'(rem_m), 0);
        chk("soak_done_busy", int'(busy_m), 0);

        // Wash right after soaked: one IDLE cycle, then load 30.
        set_ph(4'b0010);
        step(1);
        chk("idle_gap_busy", int'(busy_m), 0);
        chk("idle_gap_rem", int'(rem_m), 0);
        step(1);
        l = cyc;
        chk("wash_load", int'(rem_m), 30);
        expect_pulse(0, 4'b0010, l + 30);
        step(30);
        chk("wash_end_busy", int'(busy_m), 0);
        step(2);
        set_ph(4'b0000);
        step(1);

        // Cancel at remaining 7.
        set_ph(4'b0001);
        step(1);
        step(13);
        chk("cancel_at7", int'(rem_m), 7);
        set_ph(4'b0000);
        step(1);
        chk("cancel_rem0", int'(rem_m), 0);
        chk("cancel_busy", int'(busy_m), 0);
        step(25);

        // Multi-hot from IDLE and from RUN.
        set_ph(4'b0011);
        step(1);
        chk("multi_err", int'(err_m), 1);
        chk("multi_rem", int'(rem_m), 0);
        set_ph(4'b0001);
        step(1);
        chk("legal_err", int'(err_m), 0);
        chk("legal_load", int'(rem_m), 20);
        step(3);
        chk("run_rem17", int'(rem_m), 17);
        set_ph(4'b0011);
        step(1);
        chk("multi_run_err", int'(err_m), 1);
        chk("multi_run_busy", int'(busy_m), 0);
        chk("multi_run_rem", int'(rem_m), 0);
        set_ph(4'b0001);
        step(3);

        // Switch to rinse mid-run: reload, no soak pulse.
        set_ph(4'b0100);
        step(1);
        l = cyc;
        chk("switch_rem", int'(rem_m), 20);
        chk("switch_busy", int'(busy_m), 1);
        expect_pulse(0, 4'b0100, l + 20);
        step(20);
        set_ph(4'b0000);
        step(1);

        // Level priority 3 over 1; spin = 5*3.
        ready1 = 1'b1; ready3 = 1'b1; step(1); ready1 = 1'b0; ready3 = 1'b0;
        set_ph(4'b1000);
        step(1);
        chk("lvl3_spin", int'(rem_m), 15);
        set_ph(4'b0000);
        step(1);

        // Narrow instance: saturation, then reset mid-run with tick active.
        rst_s = 1'b0;
        step(1);
        ready3 = 1'b1; step(1); ready3 = 1'b0;
        set_ph(4'b0001);
        step(1);
        chk("sat_rem", int'(rem_s), 15);
        chk("wide_rem", int'(rem_m), 30);
        step(10);
        chk("small_rem5", int'(rem_s), 5);
        rst_s = 1'b1;
        step(1);
        chk("rst_mid_rem", int'(rem_s), 0);
        chk("rst_mid_busy", int'(busy_s), 0);
        chk("rst_mid_err", int'(err_s), 0);
        rst_s = 1'b0;
        step(1);
        chk("rst_level1", int'(rem_s), 10);
        rst_s = 1'b1;
        set_ph(4'b0000);
        step(2);

`ifdef PHASE_TIMER_PAUSE_EN
        ready2 = 1'b1; step(1); ready2 = 1'b0;
        set_ph(4'b0010);
        step(1);
        l = cyc;
        expect_pulse(0, 4'b0010, l + 38);
        step(10);
        chk("pause_pre", int'(rem_m), 20);
        door_open = 1'b1;
        step(8);
        chk("paused", int'(paused_m), 1);
        chk("pause_frozen", int'(rem_m), 20);
        door_open = 1'b0;
        step(1);
        chk("unpaused", int'(paused_m), 0);
        chk("pause_resume", int'(rem_m), 19);
        step(19);
        chk("pause_done_busy", int'(busy_m), 0);
        set_ph(4'b0000);
        step(1);
`endif

        step(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the remaining-tick counter.
REQ-002 Parameter SOAK_BASE, default 10, sets soak ticks per program level.
REQ-003 Parameter WASH_BASE, default 15, sets wash ticks per program level.
REQ-004 Parameter RINSE_BASE, default 10, sets rinse ticks per program level.
REQ-005 Parameter SPIN_BASE, default 5, sets spin ticks per program level.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tick  in  1  one-cycle time-base strobe.
REQ-009 ready1, ready2, ready3  in  1 each  controller ready flags; select program level.
REQ-010 soak, wash, rinse, spin  in  1 each  controller phase enables.
REQ-011 soaked, washed, rinsed, spun  out  1 each  registered one-cycle phase-done pulses.
REQ-012 remaining  out  CNT_W  ticks left in the current phase.
REQ-013 busy  out  1  high while in state RUN.
REQ-014 phase_err  out  1  registered; high when more than one phase enable is high.

Function
REQ-015 The level register SHALL update on every edge where any readyN is high (priority 3>2>1), and SHALL otherwise hold.
REQ-016 The phase duration SHALL be BASE*level, computed in CNT_W+2 bits and saturated to 2^CNT_W-1.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 In IDLE with exactly one phase enable high, the next edge SHALL latch that phase, load remaining=duration and enter RUN.
REQ-019 In RUN, each tick SHALL decrement remaining; the tick sampled at the loading edge SHALL be ignored.
REQ-020 In RUN, a tick with remaining==1 SHALL set remaining=0, pulse the matching done output for exactly the next cycle and enter DONE.
REQ-021 Total latency SHALL be D ticks from the load edge to the done pulse, where D is the phase duration.
REQ-022 DONE SHALL hold until the phase vector differs from the latched phase, then return to IDLE with no extra pulse.
REQ-023 A new single phase in DONE SHALL be loaded in the following IDLE cycle, giving one cycle of IDLE.
REQ-024 In RUN, if all enables drop (cancel), the next edge SHALL return to IDLE with remaining=0 and no pulse.
REQ-025 In RUN, if the enables change to a different single phase, the next edge SHALL reload that phase's duration and stay in RUN with no pulse.
REQ-026 With multi-hot enables in any state, phase_err SHALL be high, the block SHALL go to IDLE and remaining SHALL be 0; phase_err SHALL clear once the vector is legal.
REQ-027 Done pulses SHALL never overlap, and SHALL never be emitted outside the DONE-entry edge.

Reset
REQ-028 On rst, state SHALL be IDLE, level=1, remaining=0, all done pulses=0, busy=0 and phase_err=0.
REQ-029 rst asserted mid-RUN SHALL abort the phase with no pulse, and rst SHALL take priority over tick.

Configuration
REQ-030 When PHASE_TIMER_PAUSE_EN is defined, the block SHALL add input door_open (1 bit) and output paused (1 bit), and ticks in RUN SHALL be ignored while door_open=1.
REQ-031 With PHASE_TIMER_PAUSE_EN defined, paused SHALL be registered and equal to RUN&&door_open, and cancel SHALL still abort while paused.
REQ-032 When PHASE_TIMER_PAUSE_EN is undefined, door_open and paused SHALL be absent and counting SHALL never stall.

Structure
REQ-033 Package washer_pkg SHALL hold the FSM state enum, the one-hot phase encoding (SOAK, WASH, RINSE, SPIN) and the level type (2 bits).
REQ-034 A sub-module tick_down_counter SHALL provide load, decrement-on-enable and the zero/one flags.

Verification
REQ-035 ready2, then soak held with tick every cycle: remaining loads 20, soaked pulses 20 ticks after load for 1 cycle, busy falls.
REQ-036 soaked followed by wash the next cycle: one IDLE cycle, then remaining=30 with level 2, then washed pulses.
REQ-037 soak removed at remaining=7: IDLE next edge, remaining=0, no soaked pulse ever.
REQ-038 soak and wash both high: phase_err=1, remaining=0, no pulse; soak alone afterwards: phase_err=0 and a normal load.
REQ-039 CNT_W=4, SOAK_BASE=10, ready3: remaining saturates at 15; rst at remaining=5: all outputs return to reset values next cycle.
REQ-040 PHASE_TIMER_PAUSE_EN defined, door_open high for 8 ticks mid-wash: paused=1 and remaining frozen, done is delayed by exactly 8 ticks.
